divider: RTL and testbench
==========================

Name: divider

Overview:
- Iterative radix-2 restoring integer divider for the core's M-extension execute path.
- Accepts two 32-bit operands with independent signedness flags.
- Produces quotient and remainder after a fixed multi-cycle latency, with a one-cycle data_valid strobe.
- Semantics match RISC-V DIV/DIVU/REM/REMU, including divide-by-zero and overflow.

Parameters:
- WIDTH, 32, operand/result width in bits (only 32 is verified).

Ports:
- clock  input  1  rising-edge clock.
- reset_n  input  1  asynchronous active-low reset.
- input_a  input  WIDTH  dividend.
- input_b  input  WIDTH  divisor.
- signed_a  input  1  1 = input_a is two's complement, 0 = unsigned.
- signed_b  input  1  1 = input_b is two's complement, 0 = unsigned.
- enable  input  1  start request, sampled only in IDLE.
- output_quotient  output  WIDTH  registered quotient.
- output_remainder  output  WIDTH  registered remainder.
- data_valid  output  1  one-cycle strobe: results are valid.

Behaviour:
- Reset: async on reset_n low. State=IDLE; output_quotient=0, output_remainder=0, data_valid=0; all internal registers cleared. Reset mid-operation aborts the division with no data_valid.
- States: IDLE -> BUSY -> DONE -> IDLE.
- IDLE:
  - On a clock edge with enable=1: latch the magnitudes of both operands (negate if the sign flag is set and MSB=1).
  - Latch sign info: quotient negative = neg_a XOR neg_b; remainder negative = neg_a.
  - Clear the partial remainder, load the iteration counter with WIDTH, go to BUSY.
- BUSY: one restoring step per cycle.
  - Shift {rem, quo} left by 1.
  - Trial-subtract divisor magnitude from rem (WIDTH+1 bits). If non-negative, keep the difference and set quo LSB=1.
  - After WIDTH steps go to DONE.
- DONE:
  - Apply sign correction (two's-complement negate where required).
  - Register output_quotient and output_remainder; data_valid=1 for exactly this cycle; return to IDLE.
- Latency: enable sampled at edge N -> data_valid high after edge N+WIDTH+1 (33 for WIDTH=32). Throughput: one division per WIDTH+2 cycles.
- enable held high continuously: a new division starts on the first IDLE edge after DONE, so data_valid pulses every WIDTH+2 cycles.
- enable and operand changes during BUSY/DONE are ignored; operands are captured only at start.
- Outputs hold their last result until the next DONE.
- Divide by zero: quotient = all ones (0xFFFFFFFF); remainder = input_a unchanged (original signed/unsigned bits). Latency is the same as a normal division.
- Signed overflow (signed_a=signed_b=1, a=0x80000000, b=0xFFFFFFFF): quotient=0x80000000, remainder=0.
- Rounding: signed division truncates toward zero; remainder takes the sign of the dividend; |rem| < |b|.
- Mixed signedness is allowed: each operand is interpreted independently by its own flag.

Optional Feature:
- Macro DIVIDER_FAST_PATH_EN.
- Defined: in IDLE on start, if divisor==0 or |a|<|b| (magnitudes), skip BUSY and go straight to DONE.
  - Divisor==0: zero-divide results.
  - |a|<|b|: quotient 0, remainder a.
  - data_valid then rises after edge N+1.
- Not defined: every operation takes the fixed WIDTH+1 latency. Results are identical in both builds; only latency differs.

Decomposition:
- Package divider_pkg:
  - WIDTH default constant.
  - State enum typedef (IDLE, BUSY, DONE).
  - Counter width constant ($clog2(WIDTH)+1).
  - Function for conditional two's-complement negate.
- Optional sub-module divider_step: combinational one-bit restoring step (inputs rem, quo, divisor; outputs next rem, quo). Otherwise keep everything in a single module.

Test Plan:
- Unsigned basic: a=15634654, b=21354, signed=0/0, enable=1 held -> data_valid pulse 33 cycles after start; quotient=732, remainder=3526; repeats every 34 cycles.
- Signed mixes: a=-7 (0xFFFFFFF9), b=2, both signed -> q=-3 (0xFFFFFFFD), r=-1. a=7, b=-2 -> q=-3, r=1. Unsigned a=0xFFFFFFF9, b=2 -> q=0x7FFFFFFC, r=1.
- Divide by zero: a=1234, b=0 (signed and unsigned) -> q=0xFFFFFFFF, r=1234. a=-5 signed, b=0 -> r=0xFFFFFFFB.
- Overflow: a=0x80000000, b=0xFFFFFFFF, both signed -> q=0x80000000, r=0. Same operands unsigned -> q=0, r=0x80000000.
- Reset and operand capture:
  - Assert reset_n=0 mid-BUSY -> outputs 0, no data_valid; restart after release gives the correct result.
  - Changing input_a/input_b during BUSY does not alter the result.
- DIVIDER_FAST_PATH_EN defined: a=3, b=10 -> q=0, r=3, data_valid after 2 edges; a=100, b=7 -> q=14, r=2 at full latency.

Source files
------------

// File: rtl/divider_pkg.sv
// Shared types, constants and helpers for the radix-2 restoring divider.
package divider_pkg;

    localparam int DIV_WIDTH = 32;
    localparam int CNT_W     = $clog2(DIV_WIDTH) + 1;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        BUSY = 2'd1,
        DONE = 2'd2
    } state_t;

    function automatic logic [DIV_WIDTH-1:0] negate_if(
        input logic [DIV_WIDTH-1:0] val,
        input logic                 neg
    );
        return neg ? (~val + DIV_WIDTH'(1)) : val;
    endfunction

endpackage

// File: rtl/divider_step.sv
// One combinational restoring-division step: shift {rem, quo} left, trial-subtract the divisor.
module divider_step #(
    parameter int WIDTH = 32
) (
    input  logic [WIDTH-1:0] rem,
    input  logic [WIDTH-1:0] quo,
    input  logic [WIDTH-1:0] divisor,
    output logic [WIDTH-1:0] rem_next,
    output logic [WIDTH-1:0] quo_next
);

    logic [WIDTH:0] shifted;
    logic [WIDTH:0] diff;

    always_comb begin
        shifted = {rem, quo[WIDTH-1]};
        diff    = shifted - {1'b0, divisor};
        if (!diff[WIDTH]) begin
            rem_next = diff[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b1};
        end else begin
            rem_next = shifted[WIDTH-1:0];
            quo_next = {quo[WIDTH-2:0], 1'b0};
        end
    end

endmodule

// File: rtl/divider.sv
// Iterative signed/unsigned divider (RISC-V DIV/REM semantics), WIDTH+1 cycles start-to-valid.
// No backpressure: enable is only sampled in IDLE. DIVIDER_FAST_PATH_EN finishes x/0 and |a|<|b| in 1 cycle.
module divider
    import divider_pkg::*;
#(
    parameter int WIDTH = DIV_WIDTH
) (
    input  logic             clock,
    input  logic             reset_n,
    input  logic [WIDTH-1:0] input_a,
    input  logic [WIDTH-1:0] input_b,
    input  logic             signed_a,
    input  logic             signed_b,
    input  logic             enable,
    output logic [WIDTH-1:0] output_quotient,
    output logic [WIDTH-1:0] output_remainder,
    output logic             data_valid
);

    state_t             state, state_nxt;
    logic [WIDTH-1:0]   rem_q, quo_q, dvs_q;
    logic [WIDTH-1:0]   rem_step, quo_step;
    logic [CNT_W-1:0]   cnt_q;
    logic               neg_quo_q, neg_rem_q, zero_div_q;

    logic               neg_a, neg_b;
    logic [WIDTH-1:0]   mag_a, mag_b;
    logic               fast_hit;

    assign neg_a = signed_a & input_a[WIDTH-1];
    assign neg_b = signed_b & input_b[WIDTH-1];
    assign mag_a = negate_if(input_a, neg_a);
    assign mag_b = negate_if(input_b, neg_b);

`ifdef DIVIDER_FAST_PATH_EN
    assign fast_hit = (mag_b == '0) || (mag_a < mag_b);
`else
    assign fast_hit = 1'b0;
`endif

    divider_step #(.WIDTH(WIDTH)) u_step (
        .rem      (rem_q),
        .quo      (quo_q),
        .divisor  (dvs_q),
        .rem_next (rem_step),
        .quo_next (quo_step)
    );

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    always_comb begin
        state_nxt = state;
        case (state)
            IDLE: if (enable) state_nxt = fast_hit ? DONE : BUSY;
            BUSY: if (cnt_q == CNT_W'(1)) state_nxt = DONE;
            DONE: state_nxt = IDLE;
            default: state_nxt = IDLE;
        endcase
    end

    always_ff @(posedge clock or negedge reset_n) begin
        if (!reset_n) begin
            rem_q            <= '0;
            quo_q            <= '0;
            dvs_q            <= '0;
            cnt_q            <= '0;
            neg_quo_q        <= 1'b0;
            neg_rem_q        <= 1'b0;
            zero_div_q       <= 1'b0;
            output_quotient  <= '0;
            output_remainder <= '0;
            data_valid       <= 1'b0;
        end else begin
            data_valid <= 1'b0;
            case (state)
                IDLE: begin
                    if (enable) begin
                        dvs_q      <= mag_b;
                        neg_quo_q  <= neg_a ^ neg_b;
                        neg_rem_q  <= neg_a;
                        zero_div_q <= (input_b == '0);
                        cnt_q      <= CNT_W'(WIDTH);
                        // Fast path already knows the answer: remainder is |a|, quotient 0
                        // (divide-by-zero quotient is forced at DONE anyway).
                        if (fast_hit) begin
                            rem_q <= mag_a;
                            quo_q <= '0;
                        end else begin
                            rem_q <= '0;
                            quo_q <= mag_a;
                        end
                    end
                end
                BUSY: begin
                    rem_q <= rem_step;
                    quo_q <= quo_step;
                    cnt_q <= cnt_q - CNT_W'(1);
                end
                DONE: begin
                    // With a zero divisor the remainder naturally ends as |a|, so its
                    // sign correction restores the original dividend bits.
                    output_quotient  <= zero_div_q ? '1 : negate_if(quo_q, neg_quo_q);
                    output_remainder <= negate_if(rem_q, neg_rem_q);
                    data_valid       <= 1'b1;
                end
                default: ;
            endcase
        end
    end

endmodule

// File: tb/tb_divider.sv
// Scoreboard bench for divider: stimulus pushes expected results, a monitor pops on data_valid.
module tb_divider;

    logic        clock = 1'b0;
    logic        reset_n;
    logic [31:0] input_a, input_b;
    logic        signed_a, signed_b, enable;
    logic [31:0] output_quotient, output_remainder;
    logic        data_valid;

`ifdef DIVIDER_FAST_PATH_EN
    localparam bit FAST = 1'b1;
`else
    localparam bit FAST = 1'b0;
`endif

    typedef struct {
        logic [31:0] q;
        logic [31:0] r;
        int          cyc;
        string       name;
    } exp_t;

    exp_t        sb[$];
    exp_t        mon_e;
    int          checks = 0;
    int          errors = 0;
    int          cyc    = 0;
    logic [31:0] last_q, last_r;

    divider dut (
        .clock            (clock),
        .reset_n          (reset_n),
        .input_a          (input_a),
        .input_b          (input_b),
        .signed_a         (signed_a),
        .signed_b         (signed_b),
        .enable           (enable),
        .output_quotient  (output_quotient),
        .output_remainder (output_remainder),
        .data_valid       (data_valid)
    );

    always #5 clock = ~clock;
    always @(posedge clock) cyc <= cyc + 1;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask

    // Monitor: every data_valid must match the oldest outstanding expectation.
    always @(negedge clock) begin
        if (reset_n && data_valid) begin
            if (sb.size() == 0) begin
                checks++;
                errors++;
                $display("FAIL spurious_valid: got data_valid=1 expected 0 at cycle %0d", cyc);
            end else begin
                mon_e = sb.pop_front();
                check({mon_e.name, "_q"}, output_quotient, mon_e.q);
                check({mon_e.name, "_r"}, output_remainder, mon_e.r);
                check({mon_e.name, "_cycle"}, 32'(cyc), 32'(mon_e.cyc));
            end
        end
    end

    task automatic push_exp(input string name, input logic [31:0] q, input logic [31:0] r, input int at);
        exp_t e;
        e.q = q; e.r = r; e.cyc = at; e.name = name;
        sb.push_back(e);
        last_q = q;
        last_r = r;
    endtask

    task automatic wait_done(input string name);
        int n = 0;
        while (sb.size() != 0 && n < 80) begin
            @(negedge clock);
            n++;
        end
        if (sb.size() != 0) begin
            checks++;
            errors++;
            $display("FAIL %s_timeout: got %0d results pending expected 0", name, sb.size());
            sb.delete();
        end
        repeat (2) @(negedge clock);
        check({name, "_hold_q"}, output_quotient, last_q);
        check({name, "_hold_r"}, output_remainder, last_r);
    endtask

    task automatic run_div(input string name, input logic [31:0] a, input logic [31:0] b,
                           input bit sa, input bit sgb, input logic [31:0] q, input logic [31:0] r,
                           input bit fast, input bit scramble);
        @(negedge clock);
        input_a = a; input_b = b; signed_a = sa; signed_b = sgb; enable = 1'b1;
        push_exp(name, q, r, cyc + 1 + ((FAST && fast) ? 1 : 33));
        @(negedge clock);
        enable = 1'b0;
        if (scramble) begin
            input_a = $urandom; input_b = $urandom; signed_a = ~sa; signed_b = ~sgb;
            repeat (3) @(negedge clock);
            enable = 1'b1;
            input_a = $urandom; input_b = 32'd0;
            repeat (3) @(negedge clock);
            enable = 1'b0;
        end
        wait_done(name);
    endtask

    initial begin
        int base;
        reset_n = 1'b0;
        input_a = '0; input_b = '0; signed_a = 1'b0; signed_b = 1'b0; enable = 1'b0;
        #2;
        check("reset_q", output_quotient, 32'd0);
        check("reset_r", output_remainder, 32'd0);
        check("reset_valid", {31'd0, data_valid}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;

        run_div("u_basic",   32'd15634654, 32'd21354,   0, 0, 32'd732,      32'd3526,     0, 0);
        run_div("s_neg7_2",  32'hFFFFFFF9, 32'd2,       1, 1, 32'hFFFFFFFD, 32'hFFFFFFFF, 0, 0);
        run_div("s_7_neg2",  32'd7,        32'hFFFFFFFE, 1, 1, 32'hFFFFFFFD, 32'd1,       0, 0);
        run_div("u_big_2",   32'hFFFFFFF9, 32'd2,       0, 0, 32'h7FFFFFFC, 32'd1,        0, 0);
        run_div("mix_u_s",   32'hFFFFFFF9, 32'hFFFFFFFE, 0, 1, 32'h80000004, 32'd1,       0, 0);
        run_div("mix_s_u",   32'hFFFFFFF9, 32'hFFFFFFFE, 1, 0, 32'd0,       32'hFFFFFFF9, 1, 0);
        run_div("dz_s",      32'd1234,     32'd0,       1, 1, 32'hFFFFFFFF, 32'd1234,     1, 0);
        run_div("dz_u",      32'd1234,     32'd0,       0, 0, 32'hFFFFFFFF, 32'd1234,     1, 0);
        run_div("dz_neg5",   32'hFFFFFFFB, 32'd0,       1, 1, 32'hFFFFFFFF, 32'hFFFFFFFB, 1, 0);
        run_div("dz_u_big",  32'hFFFFFFF9, 32'd0,       0, 0, 32'hFFFFFFFF, 32'hFFFFFFF9, 1, 0);
        run_div("ovf_s",     32'h80000000, 32'hFFFFFFFF, 1, 1, 32'h80000000, 32'd0,       0, 0);
        run_div("ovf_u",     32'h80000000, 32'hFFFFFFFF, 0, 0, 32'd0,       32'h80000000, 1, 0);
        run_div("small_3_10", 32'd3,       32'd10,      0, 0, 32'd0,        32'd3,        1, 0);
        run_div("u_100_7",   32'd100,      32'd7,       0, 0, 32'd14,       32'd2,        0, 0);
        run_div("capture",   32'd15634654, 32'd21354,   0, 0, 32'd732,      32'd3526,     0, 1);

        // Enable held high: back-to-back divisions every 34 cycles.
        @(negedge clock);
        input_a = 32'd15634654; input_b = 32'd21354; signed_a = 1'b0; signed_b = 1'b0;
        enable = 1'b1;
        base = cyc;
        for (int i = 0; i < 3; i++)
            push_exp($sformatf("held%0d", i), 32'd732, 32'd3526, base + 1 + 34 * i + 33);
        repeat (102) @(negedge clock);
        enable = 1'b0;
        wait_done("held");

        // Reset in the middle of BUSY aborts without a result.
        @(negedge clock);
        input_a = 32'd1000; input_b = 32'd3; enable = 1'b1;
        @(negedge clock);
        enable = 1'b0;
        repeat (10) @(negedge clock);
        reset_n = 1'b0;
        #1;
        check("midrst_q", output_quotient, 32'd0);
        check("midrst_r", output_remainder, 32'd0);
        check("midrst_valid", {31'd0, data_valid}, 32'd0);
        @(negedge clock);
        reset_n = 1'b1;
        repeat (40) @(negedge clock);
        run_div("after_rst", 32'd100, 32'd7, 0, 0, 32'd14, 32'd2, 0, 0);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation did not finish, errors so far %0d", errors);
        $fatal(1, "watchdog");
    end

endmodule
